// File: rtl/fp_pkg.sv
// Shared binary32 field widths, constants and result/flag types for the FP adder pipeline.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef struct packed {
        logic [31:0] result;
        fp_flags_t   flags;
    } pack_entry_t;

endpackage

// File: rtl/fp_skid_buf2.sv
// Generic 2-entry valid/ready FIFO buffer; output is always taken from the head register.
module fp_skid_buf2 #(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inValid,
    output logic inReady,
    input  T     inData,
    output logic outValid,
    input  logic outReady,
    output T     outData
);

    logic [1:0] countQ, countD;
    T           headQ, headD;
    T           tailQ, tailD;
    logic       push, pop;

    // Ready depends on occupancy only, so it never combinationally follows outReady.
    assign inReady  = (countQ < 2'd2);
    assign outValid = (countQ != 2'd0);
    assign outData  = headQ;
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

    always_comb begin
        countD = countQ;
        headD  = headQ;
        tailD  = tailQ;
        case (countQ)
            2'd0: begin
                if (push) begin
                    headD  = inData;
                    countD = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    headD = inData;
                end else if (push) begin
                    tailD  = inData;
                    countD = 2'd2;
                end else if (pop) begin
                    countD = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    headD  = tailQ;
                    countD = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countQ <= 2'd0;
            headQ  <= '0;
            tailQ  <= '0;
        end else begin
            countQ <= countD;
            headQ  <= headD;
            tailQ  <= tailD;
        end
    end

endmodule

// File: rtl/fp_pack_stage.sv
// FP adder final stage: resolves specials/rounding carry, packs binary32, buffers 2 results.
// Define FPPACK_FLAGS_EN to add the out_flags port and per-entry flag storage.
module fp_pack_stage #(
    parameter int unsigned DEPTH = 2,
    parameter logic [31:0] QNAN  = fp_pkg::QNAN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        norm_sign,
    input  logic [7:0]  norm_exp,
    input  logic [22:0] norm_mant,
    input  logic        round_ovf,
    input  logic        eff_sub,
    input  logic        a_nan,
    input  logic        b_nan,
    input  logic        a_inf,
    input  logic        b_inf,
    input  logic        inf_sign,
    input  logic        in_inexact,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
`ifdef FPPACK_FLAGS_EN
    ,
    output logic [3:0]  out_flags
`endif
);

    import fp_pkg::*;

    if (DEPTH != 2) begin : gDepthCheck
        $error("fp_pack_stage supports DEPTH == 2 only");
    end

    logic [8:0]  e9;
    logic [31:0] pkResult;
    fp_flags_t   pkFlags;

    always_comb begin
        e9       = {1'b0, norm_exp} + {8'd0, round_ovf};
        pkResult = '0;
        pkFlags  = '0;
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            pkResult        = QNAN;
            pkFlags.invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            pkResult = {inf_sign, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (e9 >= 9'd255) begin
            pkResult         = {norm_sign, EXP_MAX, {FRAC_W{1'b0}}};
            pkFlags.overflow = 1'b1;
            pkFlags.inexact  = 1'b1;
        end else if (norm_exp == '0 && norm_mant == '0 && !round_ovf) begin
            // Exact cancellation under round-to-nearest-even yields +0.
            pkResult        = {norm_sign & ~eff_sub, 31'h0};
            pkFlags.inexact = in_inexact;
        end else if (norm_exp == '0 && norm_mant != '0) begin
            pkResult          = {norm_sign, 8'h00, norm_mant};
            pkFlags.underflow = in_inexact;
            pkFlags.inexact   = in_inexact;
        end else begin
            pkResult        = {norm_sign, e9[7:0], round_ovf ? 23'h0 : norm_mant};
            pkFlags.inexact = in_inexact;
        end
    end

`ifdef FPPACK_FLAGS_EN
    pack_entry_t pushEntry;
    pack_entry_t headEntry;

    assign pushEntry  = '{result: pkResult, flags: pkFlags};
    assign out_result = headEntry.result;
    assign out_flags  = headEntry.flags;

    fp_skid_buf2 #(
        .T (pack_entry_t)
    ) uBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .inData   (pushEntry),
        .outValid (out_valid),
        .outReady (out_ready),
        .outData  (headEntry)
    );
`else
    logic unusedFlags;
    assign unusedFlags = ^pkFlags;

    fp_skid_buf2 #(
        .T (logic [31:0])
    ) uBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .inData   (pkResult),
        .outValid (out_valid),
        .outReady (out_ready),
        .outData  (out_result)
    );
`endif

endmodule

// File: tb/tb_fp_pack_stage.sv
// Directed-vector bench for fp_pack_stage: packing rules, back-pressure ordering and reset flush.
module tb_fp_pack_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        norm_sign;
    logic [7:0]  norm_exp;
    logic [22:0] norm_mant;
    logic        round_ovf;
    logic        eff_sub;
    logic        a_nan, b_nan, a_inf, b_inf, inf_sign;
    logic        in_inexact;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
`ifdef FPPACK_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    fp_pack_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .norm_sign  (norm_sign),
        .norm_exp   (norm_exp),
        .norm_mant  (norm_mant),
        .round_ovf  (round_ovf),
        .eff_sub    (eff_sub),
        .a_nan      (a_nan),
        .b_nan      (b_nan),
        .a_inf      (a_inf),
        .b_inf      (b_inf),
        .inf_sign   (inf_sign),
        .in_inexact (in_inexact),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef FPPACK_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic setVec(input logic s, input logic [7:0] e, input logic [22:0] m,
                          input logic ovf, input logic sub, input logic an, input logic bn,
                          input logic ai, input logic bi, input logic is, input logic inx);
        norm_sign  = s;
        norm_exp   = e;
        norm_mant  = m;
        round_ovf  = ovf;
        eff_sub    = sub;
        a_nan      = an;
        b_nan      = bn;
        a_inf      = ai;
        b_inf      = bi;
        inf_sign   = is;
        in_inexact = inx;
    endtask

    // Called #1 after a posedge with out_ready=1: one push, result visible one cycle later.
    task automatic sendAndCheck(input string tag, input logic [31:0] expRes,
                                input logic [3:0] expFlags);
        checkVal({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkVal({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        checkVal({tag, ".result"}, out_result, expRes);
`ifdef FPPACK_FLAGS_EN
        checkVal({tag, ".flags"}, {28'd0, out_flags}, {28'd0, expFlags});
`else
        if (expFlags > 4'd15) $display("unreachable");
`endif
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        setVec(0, 8'h00, 23'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        checkVal("rst.out_valid", {31'd0, out_valid}, 32'd0);
        checkVal("rst.in_ready", {31'd0, in_ready}, 32'd1);
        checkVal("rst.out_result", out_result, 32'h0);
`ifdef FPPACK_FLAGS_EN
        checkVal("rst.out_flags", {28'd0, out_flags}, 32'd0);
`endif
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // flags order: {invalid, overflow, underflow, inexact}
        setVec(0, 8'h7F, 23'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        sendAndCheck("one", 32'h3F80_0000, 4'b0000);
        setVec(0, 8'h7F, 23'h0, 1, 0, 0, 0, 0, 0, 0, 1);
        sendAndCheck("carry", 32'h4000_0000, 4'b0001);
        setVec(0, 8'hFE, 23'h7FFFFF, 1, 0, 0, 0, 0, 0, 0, 1);
        sendAndCheck("ovfCarry", 32'h7F80_0000, 4'b0101);
        setVec(0, 8'hFF, 23'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        sendAndCheck("ovfExp", 32'h7F80_0000, 4'b0101);
        setVec(0, 8'h10, 23'h0, 0, 1, 0, 0, 1, 1, 0, 0);
        sendAndCheck("infMinusInf", 32'h7FC0_0000, 4'b1000);
        setVec(0, 8'h10, 23'h0, 0, 0, 0, 0, 1, 0, 1, 0);
        sendAndCheck("negInf", 32'hFF80_0000, 4'b0000);
        setVec(1, 8'h10, 23'h5, 0, 0, 0, 1, 1, 0, 1, 1);
        sendAndCheck("nanB", 32'h7FC0_0000, 4'b1000);
        setVec(1, 8'h00, 23'h0, 0, 1, 0, 0, 0, 0, 0, 0);
        sendAndCheck("cancel", 32'h0000_0000, 4'b0000);
        setVec(1, 8'h00, 23'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        sendAndCheck("negZero", 32'h8000_0000, 4'b0000);
        setVec(0, 8'h00, 23'h1, 0, 0, 0, 0, 0, 0, 0, 1);
        sendAndCheck("denorm", 32'h0000_0001, 4'b0011);
        setVec(0, 8'h00, 23'h0, 1, 0, 0, 0, 0, 0, 0, 1);
        sendAndCheck("denormCarry", 32'h0080_0000, 4'b0001);
        setVec(1, 8'h80, 23'h40_0000, 0, 1, 0, 0, 0, 0, 0, 0);
        sendAndCheck("plain", 32'hC040_0000, 4'b0000);
        @(posedge clk);
        #1;
        checkVal("drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure: third push must be refused.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setVec(0, 8'h80 + 8'(i), 23'h0, 0, 0, 0, 0, 0, 0, 0, 0);
            in_valid = 1'b1;
            checkVal($sformatf("bp.in_ready%0d", i), {31'd0, in_ready}, (i < 2) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkVal("bp.head", out_result, 32'h4000_0000);
        checkVal("bp.full", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkVal("bp.stable", out_result, 32'h4000_0000);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkVal("bp.second", out_result, 32'h4080_0000);
        checkVal("bp.second.valid", {31'd0, out_valid}, 32'd1);
        checkVal("bp.readyBack", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkVal("bp.empty", {31'd0, out_valid}, 32'd0);

        // Reset with a full buffer discards both entries.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            setVec(0, 8'h90, 23'h0, 0, 0, 0, 0, 0, 0, 0, 0);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkVal("fill.in_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkVal("midRst.out_valid", {31'd0, out_valid}, 32'd0);
        checkVal("midRst.in_ready", {31'd0, in_ready}, 32'd1);
        checkVal("midRst.out_result", out_result, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkVal("postRst.emitted", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
